// File: rtl/activation_scheduler.sv
// activation_scheduler: round-robin sharing of one LUT/interpolator activation unit across NUM_REQ requesters
module activation_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_z,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         lut_address,
    input  logic [DATA_W-1:0]         lut_base,
    input  logic [DATA_W-1:0]         lut_next,
    output logic [DATA_W-1:0]         interp_remaining,
    output logic [DATA_W-1:0]         interp_base,
    output logic [DATA_W-1:0]         interp_next,
    input  logic [DATA_W-1:0]         interp_value,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_a,
    output logic                      busy
);
    logic              s1_valid;
    logic [DATA_W-1:0] s1_z;
    logic [ID_W-1:0]   s1_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              found;
    logic              accept;
    logic              adv1;
    logic              adv2;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && req_valid[rr_ptr + ID_W'(k)]) begin
                found  = 1'b1;
                gnt_id = rr_ptr + ID_W'(k);
            end
    end

    assign accept           = rst && adv1 && found;
    assign req_ready        = accept ? NUM_REQ'(1) << gnt_id : '0;
    assign lut_address      = s1_z[DATA_W-1 -: ADDR_W];
    assign interp_remaining = DATA_W'(s1_z[DATA_W-ADDR_W-1:0]);
    assign interp_base      = lut_base;
    assign interp_next      = lut_next;
    assign busy             = s1_valid || rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_z      <= '0;
            s1_id     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_a     <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= gnt_id + ID_W'(1);
                s1_z   <= req_z[gnt_id*DATA_W +: DATA_W];
                s1_id  <= gnt_id;
            end
            if (adv1)
                s1_valid <= accept;
            if (adv2) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_id <= s1_id;
                    rsp_a  <= interp_value;
                end
            end
        end
    end
endmodule

// File: tb/tb_activation_scheduler.sv
// tb_activation_scheduler: directed tests with a simple LUT/interpolator model
module tb_activation_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_z = '0;
    logic [3:0]  req_ready;
    logic [3:0]  lut_address;
    logic [7:0]  lut_base, lut_next;
    logic [7:0]  interp_remaining, interp_base, interp_next, interp_value;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_a;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  zv [4];

    activation_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
        .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
        .interp_remaining(interp_remaining), .interp_base(interp_base), .interp_next(interp_next),
        .interp_value(interp_value), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_a(rsp_a), .busy(busy)
    );

    always #5 clk = ~clk;

    assign lut_base     = {4'h0, lut_address} * 8'd3;
    assign lut_next     = {4'h0, lut_address + 4'd1} * 8'd3;
    assign interp_value = interp_base + interp_next + interp_remaining;

    function automatic logic [7:0] exp_a(input logic [7:0] z);
        logic [3:0] a;
        a = z[7:4];
        return {4'h0, a} * 8'd3 + {4'h0, a + 4'd1} * 8'd3 + {4'h0, z[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
        checks++; if (lut_address !== 4'h0) begin errors++; $display("FAIL reset_lut_address got %0h exp 0", lut_address); end
        checks++; if (interp_remaining !== 8'h0) begin errors++; $display("FAIL reset_interp_remaining got %0h exp 0", interp_remaining); end
        checks++; if (rsp_id !== 2'd0 || rsp_a !== 8'h0) begin errors++; $display("FAIL reset_rsp_regs got %0h/%0h exp 0/0", rsp_id, rsp_a); end
    endtask

    task automatic test_single();
        req_z = 32'h0000_3500;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %0b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (lut_address !== 4'd3) begin errors++; $display("FAIL single_lut_address got %0h exp 3", lut_address); end
        checks++; if (interp_remaining !== 8'h05) begin errors++; $display("FAIL single_remaining got %0h exp 05", interp_remaining); end
        checks++; if (interp_base !== 8'd9 || interp_next !== 8'd12) begin errors++; $display("FAIL single_interp got %0d/%0d exp 9/12", interp_base, interp_next); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_stage1 got v%0h b%0h exp v0 b1", rsp_valid, busy); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp got v%0h id%0d exp v1 id1", rsp_valid, rsp_id); end
        checks++; if (rsp_a !== 8'd26) begin errors++; $display("FAIL single_rsp_a got %0d exp 26", rsp_a); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got v%0h b%0h exp v0 b0", rsp_valid, busy); end
    endtask

    task automatic test_full_load();
        do_reset();
        zv[0] = 8'h12; zv[1] = 8'h80; zv[2] = 8'h7F; zv[3] = 8'hFF;
        req_z = {zv[3], zv[2], zv[1], zv[0]};
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0001 << (c % 4)) begin errors++; $display("FAIL full_grant%0d got %0b exp %0b", c, req_ready, 4'b0001 << (c % 4)); end
            tick();
            checks++; if (lut_address !== zv[c % 4][7:4] || interp_remaining !== {4'h0, zv[c % 4][3:0]}) begin
                errors++; $display("FAIL full_lut%0d got %0h/%0h exp %0h/%0h", c, lut_address, interp_remaining, zv[c % 4][7:4], zv[c % 4][3:0]);
            end
            if (c == 0) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL full_latency got %0h exp 0", rsp_valid); end
            end else begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_a !== exp_a(zv[(c - 1) % 4])) begin
                    errors++; $display("FAIL full_rsp%0d got v%0h id%0d a%0d exp v1 id%0d a%0d", c, rsp_valid, rsp_id, rsp_a, (c - 1) % 4, exp_a(zv[(c - 1) % 4]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got r%0b b%0h exp r0000 b1", c, req_ready, busy); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_a !== exp_a(zv[0])) begin
                errors++; $display("FAIL bp_hold%0d got v%0h id%0d a%0d exp v1 id0 a%0d", c, rsp_valid, rsp_id, rsp_a, exp_a(zv[0]));
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_grant got %0b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_a !== exp_a(zv[1])) begin errors++; $display("FAIL bp_out1 got v%0h id%0d a%0d exp v1 id1 a%0d", rsp_valid, rsp_id, rsp_a, exp_a(zv[1])); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_a !== exp_a(zv[2])) begin errors++; $display("FAIL bp_out2 got v%0h id%0d a%0d exp v1 id2 a%0d", rsp_valid, rsp_id, rsp_a, exp_a(zv[2])); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got v%0h b%0h exp v0 b0", rsp_valid, busy); end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_first got %0b exp 0100", req_ready); end
        tick();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_second got %0b exp 1000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_third got %0b exp 0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_single_a got %0b exp 0010", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_single_b got %0b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1111;
        tick();
        tick();
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got b%0h v%0h exp b1 v1", busy, rsp_valid); end
        rst = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_flush got v%0h b%0h exp v0 b0", rsp_valid, busy); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %0b exp 0001", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %0h exp 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_first_rsp got v%0h id%0d exp v1 id0", rsp_valid, rsp_id); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_full_load();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
